// File: rtl/ball_axis.sv
// -----------------------------------------------------------------------------
// ball_axis
// One axis of a bouncing ball for a raster display. Holds the ball position and
// direction along this axis, advances it once per frame, clamps at the walls,
// and produces the video overlay for the scan position along the axis.
//
// Configuration macro: BALL_AUTO_BOUNCE_EN
//   defined   : a wall hit reverses direction and the ball keeps moving.
//   undefined : a wall hit scores a point; the ball shows at the wall for one
//               cycle, then recentres and waits out a new serve delay.
//
// Ports
//   i_Clk, i_Rst_N : clock (rising edge) and asynchronous active-low reset
//   i_ScanReset    : restart the scan counter at 0
//   i_ScanEn       : visible-area strobe; advances the scan counter
//   i_FrameTick    : one pulse per frame; the only trigger for motion
//   i_Speed        : requested step per frame (clamped to P_MAX_SPEED)
//   i_Flip         : request to reverse direction on the next frame tick
//   i_Serve        : recentre the ball and restart the serve delay
//   o_Video        : ball covers the current scan position (combinational)
//   o_Pos, o_Dir   : ball position (0..MAX_POS) and direction (1 = up)
//   o_HitLow/High  : one-cycle pulse when the ball reaches 0 / MAX_POS
//   o_Moving       : ball is in the MOVE state
// -----------------------------------------------------------------------------
module ball_axis #(
   parameter int unsigned P_VISIBLE      = 640,
   parameter int unsigned P_BALL_SIZE    = 8,
   parameter int unsigned P_MAX_SPEED    = 7,
   parameter int unsigned P_SERVE_FRAMES = 60,
   localparam int unsigned W             = $clog2(P_VISIBLE)
) (
   input  logic         i_Clk,
   input  logic         i_Rst_N,
   input  logic         i_ScanReset,
   input  logic         i_ScanEn,
   input  logic         i_FrameTick,
   input  logic [2:0]   i_Speed,
   input  logic         i_Flip,
   input  logic         i_Serve,
   output logic         o_Video,
   output logic [W-1:0] o_Pos,
   output logic         o_Dir,
   output logic         o_HitLow,
   output logic         o_HitHigh,
   output logic         o_Moving
);

   localparam int unsigned WE = W + 1;
   localparam int unsigned MAX_POS_I = P_VISIBLE - P_BALL_SIZE;
   localparam logic [W-1:0] MAX_POS = W'(MAX_POS_I);
   localparam logic [W-1:0] CENTER = W'(MAX_POS_I / 2);
   localparam logic [W-1:0] SCAN_LAST = W'(P_VISIBLE - 1);
   localparam logic [2:0] MAX_SPEED = 3'(P_MAX_SPEED);
   localparam logic [7:0] SERVE_LAST = 8'(P_SERVE_FRAMES - 1);

   typedef enum logic {
      StServe,
      StMove
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  scan_q, scan_d;
   logic [W-1:0]  pos_q, pos_d;
   logic          dir_q, dir_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          flip_q, flip_d;
   logic          hit_low_q, hit_low_d;
   logic          hit_high_q, hit_high_d;

   logic [2:0]    step;
   logic          dir_new;
   logic [WE-1:0] pos_ext;
   logic [WE-1:0] step_ext;
   logic [WE-1:0] pos_up;
   logic [WE-1:0] scan_ext;

   // Scan counter: reset wins over advance, saturates at the last visible pixel.
   always_comb begin
      scan_d = scan_q;
      if (i_ScanReset) begin
         scan_d = '0;
      end else if (i_ScanEn && (scan_q != SCAN_LAST)) begin
         scan_d = scan_q + W'(1);
      end
   end

   // Compare in W+1 bits so pos + size never wraps near the top edge.
   always_comb begin
      scan_ext = {1'b0, scan_q};
      o_Video  = i_ScanEn && (scan_ext >= pos_ext) && (scan_ext < pos_ext + WE'(P_BALL_SIZE));
   end

   always_comb begin
      step     = (i_Speed > MAX_SPEED) ? MAX_SPEED : i_Speed;
      pos_ext  = {1'b0, pos_q};
      step_ext = WE'(step);
      pos_up   = pos_ext + step_ext;
      // A flip arriving with the tick is applied on that tick.
      dir_new  = dir_q ^ (flip_q | i_Flip);
   end

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      flip_d     = flip_q;
      hit_low_d  = 1'b0;
      hit_high_d = 1'b0;

      if (i_Serve) begin
         pos_d   = CENTER;
         cnt_d   = '0;
         flip_d  = 1'b0;
         state_d = StServe;
      end else begin
         case (state_q)
            StServe: begin
               flip_d = 1'b0;
`ifndef BALL_AUTO_BOUNCE_EN
               // The wall position was shown for one cycle; now recentre.
               if (hit_low_q || hit_high_q) begin
                  pos_d = CENTER;
               end
`endif
               if (i_FrameTick) begin
                  if (cnt_q == SERVE_LAST) begin
                     cnt_d   = '0;
                     state_d = StMove;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            StMove: begin
               flip_d = flip_q | i_Flip;
               if (i_FrameTick) begin
                  flip_d = 1'b0;
                  dir_d  = dir_new;
                  if (step != 3'd0) begin
                     if (dir_new) begin
                        if (pos_up >= WE'(MAX_POS)) begin
                           pos_d      = MAX_POS;
                           hit_high_d = 1'b1;
                           dir_d      = 1'b0;
                        end else begin
                           pos_d = pos_up[W-1:0];
                        end
                     end else begin
                        if (pos_ext <= step_ext) begin
                           pos_d     = '0;
                           hit_low_d = 1'b1;
                           dir_d     = 1'b1;
                        end else begin
                           pos_d = pos_q - W'(step);
                        end
                     end
                  end
`ifndef BALL_AUTO_BOUNCE_EN
                  if (hit_low_d || hit_high_d) begin
                     state_d = StServe;
                     cnt_d   = '0;
                  end
`endif
               end
            end
            default: state_d = StServe;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         state_q    <= StServe;
         scan_q     <= '0;
         pos_q      <= CENTER;
         dir_q      <= 1'b1;
         cnt_q      <= '0;
         flip_q     <= 1'b0;
         hit_low_q  <= 1'b0;
         hit_high_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         scan_q     <= scan_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         flip_q     <= flip_d;
         hit_low_q  <= hit_low_d;
         hit_high_q <= hit_high_d;
      end
   end

   assign o_Pos     = pos_q;
   assign o_Dir     = dir_q;
   assign o_HitLow  = hit_low_q;
   assign o_HitHigh = hit_high_q;
   assign o_Moving  = (state_q == StMove);

endmodule

// File: tb/tb_ball_axis.sv
// -----------------------------------------------------------------------------
// tb_ball_axis
// Directed bench for ball_axis. Instance a uses default parameters, instance b
// uses P_MAX_SPEED=3; both share all inputs. Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_ball_axis;

`ifdef BALL_AUTO_BOUNCE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scan_reset = 1'b0;
   logic       scan_en = 1'b0;
   logic       frame_tick = 1'b0;
   logic [2:0] speed = 3'd0;
   logic       flip = 1'b0;
   logic       serve = 1'b0;

   logic       a_video, a_dir, a_hit_low, a_hit_high, a_moving;
   logic [9:0] a_pos;
   logic       b_video, b_dir, b_hit_low, b_hit_high, b_moving;
   logic [9:0] b_pos;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ball_axis u_a (
      .i_Clk       (clk),
      .i_Rst_N     (rst_n),
      .i_ScanReset (scan_reset),
      .i_ScanEn    (scan_en),
      .i_FrameTick (frame_tick),
      .i_Speed     (speed),
      .i_Flip      (flip),
      .i_Serve     (serve),
      .o_Video     (a_video),
      .o_Pos       (a_pos),
      .o_Dir       (a_dir),
      .o_HitLow    (a_hit_low),
      .o_HitHigh   (a_hit_high),
      .o_Moving    (a_moving)
   );

   ball_axis #(.P_MAX_SPEED(3)) u_b (
      .i_Clk       (clk),
      .i_Rst_N     (rst_n),
      .i_ScanReset (scan_reset),
      .i_ScanEn    (scan_en),
      .i_FrameTick (frame_tick),
      .i_Speed     (speed),
      .i_Flip      (flip),
      .i_Serve     (serve),
      .o_Video     (b_video),
      .o_Pos       (b_pos),
      .o_Dir       (b_dir),
      .o_HitLow    (b_hit_low),
      .o_HitHigh   (b_hit_high),
      .o_Moving    (b_moving)
   );

   // One frame tick with optional same-cycle flip / serve; returns 1 ns after the edge.
   task automatic tick(input logic [2:0] spd, input logic f, input logic s);
      speed = spd; flip = f; serve = s; frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0; flip = 1'b0; serve = 1'b0;
   endtask

   task automatic pulse_flip();
      flip = 1'b1;
      @(posedge clk); #1;
      flip = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_pos !== 10'd316) begin errors++; $display("FAIL reset_pos: got %0d want 316", a_pos); end
      checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", a_dir); end
      checks++; if (a_moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b want 0", a_moving); end
      checks++; if ({a_hit_low, a_hit_high} !== 2'b00) begin errors++; $display("FAIL reset_hits: got %b want 00", {a_hit_low, a_hit_high}); end
      checks++; if ({a_video, b_video} !== 2'b00) begin errors++; $display("FAIL reset_video: got %b want 00", {a_video, b_video}); end
      checks++; if ({b_hit_low, b_hit_high} !== 2'b00) begin errors++; $display("FAIL reset_hits_b: got %b want 00", {b_hit_low, b_hit_high}); end
      checks++; if (b_pos !== 10'd316) begin errors++; $display("FAIL reset_pos_b: got %0d want 316", b_pos); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // 60 serve ticks; a flip mid-serve must be discarded.
   task automatic test_serve();
      for (int t = 1; t <= 60; t++) begin
         if (t == 30) pulse_flip();
         tick(3'd3, 1'b0, 1'b0);
         checks++; if (a_pos !== 10'd316) begin errors++; $display("FAIL serve_pos t=%0d: got %0d want 316", t, a_pos); end
         checks++; if (a_moving !== (t == 60)) begin errors++; $display("FAIL serve_moving t=%0d: got %b want %b", t, a_moving, (t == 60)); end
      end
      checks++; if (b_moving !== 1'b1) begin errors++; $display("FAIL serve_moving_b: got %b want 1", b_moving); end
   endtask

   task automatic test_speed_clamp();
      tick(3'd7, 1'b0, 1'b0);
      checks++; if (a_pos !== 10'd323) begin errors++; $display("FAIL speed7_pos: got %0d want 323", a_pos); end
      checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL speed7_dir: got %b want 1", a_dir); end
      checks++; if (b_pos !== 10'd319) begin errors++; $display("FAIL clamp3_pos: got %0d want 319", b_pos); end
      checks++; if (b_dir !== 1'b1) begin errors++; $display("FAIL clamp3_dir: got %b want 1", b_dir); end
   endtask

   task automatic test_flip();
      tick(3'd7, 1'b1, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd316, 1'b0}) begin errors++; $display("FAIL flip_same_tick: got %0d/%b want 316/0", a_pos, a_dir); end
      checks++; if ({b_pos, b_dir} !== {10'd316, 1'b0}) begin errors++; $display("FAIL flip_same_tick_b: got %0d/%b want 316/0", b_pos, b_dir); end
      repeat (16) tick(3'd7, 1'b0, 1'b0);
      tick(3'd4, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd200, 1'b0}) begin errors++; $display("FAIL walk_down: got %0d/%b want 200/0", a_pos, a_dir); end
      // Step 0 holds position but still consumes the flip.
      pulse_flip();
      tick(3'd0, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd200, 1'b1}) begin errors++; $display("FAIL step0_flip: got %0d/%b want 200/1", a_pos, a_dir); end
      checks++; if ({a_hit_low, a_hit_high} !== 2'b00) begin errors++; $display("FAIL step0_hits: got %b want 00", {a_hit_low, a_hit_high}); end
      // Two flips before one tick collapse to a single reversal.
      pulse_flip();
      @(posedge clk); #1;
      pulse_flip();
      tick(3'd2, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd198, 1'b0}) begin errors++; $display("FAIL double_flip: got %0d/%b want 198/0", a_pos, a_dir); end
      tick(3'd2, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd196, 1'b0}) begin errors++; $display("FAIL flip_consumed: got %0d/%b want 196/0", a_pos, a_dir); end
      tick(3'd2, 1'b1, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd198, 1'b1}) begin errors++; $display("FAIL flip_up: got %0d/%b want 198/1", a_pos, a_dir); end
      tick(3'd2, 1'b1, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd196, 1'b0}) begin errors++; $display("FAIL flip_down: got %0d/%b want 196/0", a_pos, a_dir); end
   endtask

   // Serve together with a tick: serve wins, direction kept, delay restarts.
   task automatic test_serve_tick();
      tick(3'd2, 1'b0, 1'b1);
      checks++; if ({a_pos, a_dir, a_moving} !== {10'd316, 1'b0, 1'b0}) begin errors++; $display("FAIL serve_tick: got %0d/%b/%b want 316/0/0", a_pos, a_dir, a_moving); end
      for (int t = 1; t <= 60; t++) begin
         tick(3'd7, 1'b0, 1'b0);
         if (t >= 59) begin
            checks++; if (a_moving !== (t == 60)) begin errors++; $display("FAIL reserve_moving t=%0d: got %b want %b", t, a_moving, (t == 60)); end
         end
      end
      checks++; if (a_pos !== 10'd316) begin errors++; $display("FAIL reserve_pos: got %0d want 316", a_pos); end
   endtask

   task automatic test_hit_low();
      repeat (45) tick(3'd7, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd1, 1'b0}) begin errors++; $display("FAIL near_low: got %0d/%b want 1/0", a_pos, a_dir); end
      tick(3'd7, 1'b0, 1'b0);
      checks++; if (a_pos !== 10'd0) begin errors++; $display("FAIL low_clamp: got %0d want 0", a_pos); end
      checks++; if ({a_hit_low, a_hit_high} !== 2'b10) begin errors++; $display("FAIL low_pulse: got %b want 10", {a_hit_low, a_hit_high}); end
      checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL low_dir: got %b want 1", a_dir); end
      checks++; if (a_moving !== AUTO) begin errors++; $display("FAIL low_moving: got %b want %b", a_moving, AUTO); end
      @(posedge clk); #1;
      checks++; if (a_hit_low !== 1'b0) begin errors++; $display("FAIL low_pulse_end: got %b want 0", a_hit_low); end
      checks++; if (a_pos !== (AUTO ? 10'd0 : 10'd316)) begin errors++; $display("FAIL low_after: got %0d want %0d", a_pos, (AUTO ? 0 : 316)); end
   endtask

   task automatic test_hit_high();
      if (AUTO) begin
         repeat (90) tick(3'd7, 1'b0, 1'b0);
      end else begin
         repeat (60) tick(3'd7, 1'b0, 1'b0);
         repeat (44) tick(3'd7, 1'b0, 1'b0);
         tick(3'd6, 1'b0, 1'b0);
      end
      checks++; if ({a_pos, a_dir, a_moving} !== {10'd630, 1'b1, 1'b1}) begin errors++; $display("FAIL near_high: got %0d/%b/%b want 630/1/1", a_pos, a_dir, a_moving); end
      tick(3'd5, 1'b0, 1'b0);
      checks++; if (a_pos !== 10'd632) begin errors++; $display("FAIL high_clamp: got %0d want 632", a_pos); end
      checks++; if ({a_hit_low, a_hit_high} !== 2'b01) begin errors++; $display("FAIL high_pulse: got %b want 01", {a_hit_low, a_hit_high}); end
      checks++; if (a_dir !== 1'b0) begin errors++; $display("FAIL high_dir: got %b want 0", a_dir); end
      @(posedge clk); #1;
      checks++; if (a_hit_high !== 1'b0) begin errors++; $display("FAIL high_pulse_end: got %b want 0", a_hit_high); end
      checks++; if (a_pos !== (AUTO ? 10'd632 : 10'd316)) begin errors++; $display("FAIL high_after: got %0d want %0d", a_pos, (AUTO ? 632 : 316)); end
      checks++; if ({a_moving, a_dir} !== {AUTO, 1'b0}) begin errors++; $display("FAIL high_state: got %b%b want %b0", a_moving, a_dir, AUTO); end
   endtask

   task automatic test_video();
      int p;
      logic want;
      p = AUTO ? 632 : 316;
      scan_reset = 1'b1;
      @(posedge clk); #1;
      scan_reset = 1'b0;
      scan_en = 1'b1;
      for (int i = 0; i < 640; i++) begin
         want = (i >= p) && (i < p + 8);
         checks++; if (a_video !== want) begin errors++; $display("FAIL video scan=%0d: got %b want %b", i, a_video, want); end
         if (i == p) begin
            scan_en = 1'b0; #1;
            checks++; if (a_video !== 1'b0) begin errors++; $display("FAIL video_gate: got %b want 0", a_video); end
            scan_en = 1'b1;
         end
         @(posedge clk); #1;
      end
      // Counter saturates at 639.
      want = (639 >= p) && (639 < p + 8);
      checks++; if (a_video !== want) begin errors++; $display("FAIL video_sat: got %b want %b", a_video, want); end
      scan_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      pulse_flip();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({a_pos, a_dir, a_moving} !== {10'd316, 1'b1, 1'b0}) begin errors++; $display("FAIL async_reset: got %0d/%b/%b want 316/1/0", a_pos, a_dir, a_moving); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         tick(3'd1, 1'b0, 1'b0);
         if (t >= 59) begin
            checks++; if (a_moving !== (t == 60)) begin errors++; $display("FAIL rst_serve t=%0d: got %b want %b", t, a_moving, (t == 60)); end
         end
      end
      tick(3'd1, 1'b0, 1'b0);
      checks++; if ({a_pos, a_dir} !== {10'd317, 1'b1}) begin errors++; $display("FAIL rst_first_move: got %0d/%b want 317/1", a_pos, a_dir); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_serve();
      test_speed_clamp();
      test_flip();
      test_serve_tick();
      test_hit_low();
      test_hit_high();
      test_video();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_axis.md
BALL_AXIS -- requirements
Module: Ball_Axis

Interface
REQ-001 SHALL have parameter P_VISIBLE, default 640: visible pixels along the axis.
REQ-002 SHALL have parameter P_BALL_SIZE, default 8: ball extent in pixels; 1 <= P_BALL_SIZE < P_VISIBLE.
REQ-003 SHALL have parameter P_MAX_SPEED, default 7: upper clamp on step per frame; 0..7.
REQ-004 SHALL have parameter P_SERVE_FRAMES, default 60: frames the ball rests after serve; 1..255.
REQ-005 SHALL define W = $clog2(P_VISIBLE), MAX_POS = P_VISIBLE - P_BALL_SIZE, CENTER = (P_VISIBLE - P_BALL_SIZE)/2 (integer division).
REQ-006 i_Clk  in  1  sole clock; all state on rising edge.
REQ-007 i_Rst_N  in  1  asynchronous, active-low reset.
REQ-008 i_ScanReset  in  1  start of scan along this axis (line start for horizontal, frame start for vertical).
REQ-009 i_ScanEn  in  1  visible-area advance strobe; scan counter steps once per asserted cycle.
REQ-010 i_FrameTick  in  1  one-cycle pulse in blanking; sole trigger for position update.
REQ-011 i_Speed  in  3  requested step per frame, unsigned.
REQ-012 i_Flip  in  1  one-cycle request to reverse direction (paddle hit).
REQ-013 i_Serve  in  1  one-cycle request to recentre ball and restart serve delay.
REQ-014 o_Video  out  1  ball covers current scan position.
REQ-015 o_Pos  out  W  ball leading-edge position, 0..MAX_POS.
REQ-016 o_Dir  out  1  1 = increasing position, 0 = decreasing.
REQ-017 o_HitLow / o_HitHigh  out  1 each  one-cycle pulse when ball reaches 0 / MAX_POS.
REQ-018 o_Moving  out  1  high in MOVE state.

Function
REQ-019 Scan counter (W bits) SHALL load 0 when i_ScanReset, else increment when i_ScanEn, saturating at P_VISIBLE-1; i_ScanReset wins when both are asserted.
REQ-020 o_Video SHALL be combinational: i_ScanEn && scan >= o_Pos && scan < o_Pos + P_BALL_SIZE (zero latency, (W+1)-bit compare).
REQ-021 FSM states SERVE and MOVE; SERVE counts i_FrameTick pulses; on the P_SERVE_FRAMES-th tick -> MOVE, no position change on that tick.
REQ-022 In MOVE, on i_FrameTick: step = min(i_Speed, P_MAX_SPEED); dir' = o_Dir XOR flip_pending; position moves step in dir', (W+1)-bit arithmetic, no wrap.
REQ-023 Upward move with result >= MAX_POS SHALL clamp to MAX_POS and pulse o_HitHigh the next cycle; downward move with o_Pos <= step SHALL clamp to 0 and pulse o_HitLow.
REQ-024 Step 0 SHALL hold position, emit no hit pulse, and consume flip_pending (direction still updates).
REQ-025 i_Flip SHALL set flip_pending; flip_pending SHALL clear on the MOVE frame tick that applies it; multiple flips before a tick collapse to one; i_Flip on the same cycle as the tick is applied on that tick.
REQ-026 i_Flip in SERVE SHALL be ignored and flip_pending cleared.
REQ-027 On wall hit, resulting direction SHALL point away from that wall regardless of flip_pending (wall wins).
REQ-028 i_Serve SHALL, from either state, load o_Pos = CENTER, clear serve counter and flip_pending, enter SERVE, keep o_Dir; i_Serve wins over a simultaneous i_FrameTick.
REQ-029 o_Pos, o_Dir, hit pulses SHALL be registered; o_Pos updates the cycle after i_FrameTick.

Reset
REQ-030 While i_Rst_N low: o_Pos = CENTER, o_Dir = 1, state SERVE, serve counter 0, scan 0, flip_pending 0, o_HitLow = o_HitHigh = 0, o_Moving = 0.
REQ-031 Reset mid-frame SHALL abort any pending update; first tick after release counts as serve frame 1.

Configuration
REQ-032 Macro BALL_AUTO_BOUNCE_EN defined: wall hit reverses direction (REQ-027), state stays MOVE.
REQ-033 Macro BALL_AUTO_BOUNCE_EN undefined: wall hit still clamps and pulses, then o_Pos = CENTER, o_Dir inverted, state SERVE (point scored); pulses identical in both builds.

Verification
REQ-034 Reset release, 60 ticks, P_VISIBLE=640, P_BALL_SIZE=8 -> o_Pos=316 throughout, o_Moving rises after tick 60.
REQ-035 MOVE, o_Pos=630, o_Dir=1, i_Speed=5, tick -> o_Pos=632, o_HitHigh one cycle; EN build o_Dir=0, non-EN build o_Pos=316 in SERVE with o_Dir=0.
REQ-036 i_Speed=7 with P_MAX_SPEED=3, o_Pos=100, o_Dir=1 -> o_Pos=103 after tick.
REQ-037 i_Flip twice mid-frame at o_Pos=200, o_Dir=1, i_Speed=2 -> after tick o_Pos=198, o_Dir=0; next tick o_Pos=196.
REQ-038 o_Pos=40, scan 0..639 with i_ScanEn -> o_Video high exactly for scan 40..47; i_Serve with tick in same cycle -> o_Pos=316, SERVE.
